// File: rtl/uart_ctrl_pkg.sv
// Shared command codes, FSM state encoding and default widths for the UART command controller.
package uart_ctrl_pkg;

    localparam int unsigned DEF_DATA_WIDTH     = 8;
    localparam int unsigned DEF_ADDR_WIDTH     = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

    localparam logic [7:0] CMD_WR = 8'hAA;
    localparam logic [7:0] CMD_RD = 8'hBB;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_TX_REQ,
        ST_TX_HOLD
    } ctrl_state_t;

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte idle counter; saturates and flags expiry once TIMEOUT_CYCLES idle cycles have elapsed.
module uart_frame_timer
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear || !count_en) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame parser / register-file sequencer between the UART datapath and the register file.
// Optional inter-byte frame timeout is enabled by defining FRAME_TIMEOUT_EN.
module uart_cmd_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_BUSY,
    output logic [ADDR_WIDTH-1:0] RF_ADDR,
    output logic [DATA_WIDTH-1:0] RF_WR_DATA,
    output logic                  RF_WR_EN,
    output logic                  RF_RD_EN,
    input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
    input  logic                  RF_RD_VLD,
    output logic                  CTRL_BUSY,
    output logic                  CMD_ERR
);

    ctrl_state_t state;
    logic        addr_ok;
    logic        timed_out;

    assign addr_ok   = ((RX_P_DATA >> ADDR_WIDTH) == '0);
    assign CTRL_BUSY = (state != ST_IDLE);

`ifdef FRAME_TIMEOUT_EN
    logic counting;

    assign counting = (state == ST_WR_ADDR) || (state == ST_WR_DATA) || (state == ST_RD_ADDR);

    uart_frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_timer (
        .clk     (CLK),
        .rst     (RST),
        .clear   (RX_D_VLD),
        .count_en(counting),
        .expired (timed_out)
    );
`else
    localparam int unsigned timeout_cycles_unused = TIMEOUT_CYCLES;
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            TX_P_DATA  <= '0;
            TX_D_VLD   <= 1'b0;
            RF_ADDR    <= '0;
            RF_WR_DATA <= '0;
            RF_WR_EN   <= 1'b0;
            RF_RD_EN   <= 1'b0;
            CMD_ERR    <= 1'b0;
        end else begin
            RF_WR_EN <= 1'b0;
            RF_RD_EN <= 1'b0;
            CMD_ERR  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (RX_D_VLD) begin
                        if (RX_P_DATA == DATA_WIDTH'(CMD_WR)) begin
                            state <= ST_WR_ADDR;
                        end else if (RX_P_DATA == DATA_WIDTH'(CMD_RD)) begin
                            state <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR_ADDR, ST_RD_ADDR: begin
                    if (RX_D_VLD) begin
                        if (addr_ok) begin
                            RF_ADDR <= RX_P_DATA[ADDR_WIDTH-1:0];
                            if (state == ST_RD_ADDR) begin
                                RF_RD_EN <= 1'b1;
                                state    <= ST_RD_WAIT;
                            end else begin
                                state <= ST_WR_DATA;
                            end
                        end else begin
                            CMD_ERR <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end else if (timed_out) begin
                        CMD_ERR <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                ST_WR_DATA: begin
                    if (RX_D_VLD) begin
                        RF_WR_DATA <= RX_P_DATA;
                        RF_WR_EN   <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (timed_out) begin
                        CMD_ERR <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                ST_RD_WAIT: begin
                    CMD_ERR <= RX_D_VLD;
                    // Going straight to TX_HOLD when the transmitter is idle gives the one-cycle read-to-TX latency.
                    if (RF_RD_VLD) begin
                        TX_P_DATA <= RF_RD_DATA;
                        if (!TX_BUSY) begin
                            TX_D_VLD <= 1'b1;
                            state    <= ST_TX_HOLD;
                        end else begin
                            state <= ST_TX_REQ;
                        end
                    end
                end
                ST_TX_REQ: begin
                    CMD_ERR <= RX_D_VLD;
                    if (!TX_BUSY) begin
                        TX_D_VLD <= 1'b1;
                        state    <= ST_TX_HOLD;
                    end
                end
                ST_TX_HOLD: begin
                    CMD_ERR <= RX_D_VLD;
                    if (TX_BUSY) begin
                        TX_D_VLD <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: write/read frames, TX backpressure, error frames, reset and timeout.
module tb_uart_cmd_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] RX_P_DATA = '0;
    logic       RX_D_VLD = 1'b0;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       TX_BUSY = 1'b0;
    logic [3:0] RF_ADDR;
    logic [7:0] RF_WR_DATA;
    logic       RF_WR_EN;
    logic       RF_RD_EN;
    logic [7:0] RF_RD_DATA = '0;
    logic       RF_RD_VLD = 1'b0;
    logic       CTRL_BUSY;
    logic       CMD_ERR;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned wr_cnt = 0;
    int unsigned rd_cnt = 0;
    int unsigned err_cnt = 0;
    int unsigned both_cnt = 0;
    logic [3:0]  last_wr_addr = '0;

    uart_cmd_ctrl #(
        .DATA_WIDTH    (8),
        .ADDR_WIDTH    (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_P_DATA (RX_P_DATA),
        .RX_D_VLD  (RX_D_VLD),
        .TX_P_DATA (TX_P_DATA),
        .TX_D_VLD  (TX_D_VLD),
        .TX_BUSY   (TX_BUSY),
        .RF_ADDR   (RF_ADDR),
        .RF_WR_DATA(RF_WR_DATA),
        .RF_WR_EN  (RF_WR_EN),
        .RF_RD_EN  (RF_RD_EN),
        .RF_RD_DATA(RF_RD_DATA),
        .RF_RD_VLD (RF_RD_VLD),
        .CTRL_BUSY (CTRL_BUSY),
        .CMD_ERR   (CMD_ERR)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (RF_WR_EN) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= RF_ADDR;
        end
        if (RF_RD_EN) rd_cnt <= rd_cnt + 1;
        if (CMD_ERR) err_cnt <= err_cnt + 1;
        if (RF_WR_EN && RF_RD_EN) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
    endtask

    initial begin : stim
        int unsigned wr0, rd0, err0;
        logic        bad;
        logic        seen;

        tick(); tick(); tick();
        check("rst_tx_vld", TX_D_VLD, 0);
        check("rst_wr_en", RF_WR_EN, 0);
        check("rst_rd_en", RF_RD_EN, 0);
        check("rst_err", CMD_ERR, 0);
        check("rst_busy", CTRL_BUSY, 0);
        check("rst_tx_data", TX_P_DATA, 0);
        check("rst_rf_addr", RF_ADDR, 0);
        RST = 1'b0;
        tick();

        // Write AA,05,3C
        wr0 = wr_cnt; err0 = err_cnt;
        send_byte(8'hAA);
        send_byte(8'h05);
        check("wr_busy_mid", CTRL_BUSY, 1);
        send_byte(8'h3C);
        check("wr_en", RF_WR_EN, 1);
        check("wr_addr", RF_ADDR, 5);
        check("wr_data", RF_WR_DATA, 8'h3C);
        tick();
        check("wr_en_drop", RF_WR_EN, 0);
        check("wr_idle", CTRL_BUSY, 0);
        check("wr_count", wr_cnt - wr0, 1);
        check("wr_no_err", err_cnt - err0, 0);

        // Read BB,07 returning 5A two cycles after RF_RD_EN
        send_byte(8'hBB);
        send_byte(8'h07);
        check("rd_en", RF_RD_EN, 1);
        check("rd_addr", RF_ADDR, 7);
        tick();
        check("rd_en_drop", RF_RD_EN, 0);
        tick();
        RF_RD_DATA = 8'h5A; RF_RD_VLD = 1'b1;
        tick();
        RF_RD_DATA = 8'h00; RF_RD_VLD = 1'b0;
        check("rd_tx_vld", TX_D_VLD, 1);
        check("rd_tx_data", TX_P_DATA, 8'h5A);
        tick(); tick(); tick();
        check("rd_tx_hold", TX_D_VLD, 1);
        check("rd_tx_data_hold", TX_P_DATA, 8'h5A);
        TX_BUSY = 1'b1;
        tick();
        TX_BUSY = 1'b0;
        check("rd_tx_drop", TX_D_VLD, 0);
        check("rd_idle", CTRL_BUSY, 0);

        // TX backpressure for 50 cycles
        send_byte(8'hBB);
        send_byte(8'h03);
        tick();
        TX_BUSY = 1'b1;
        RF_RD_DATA = 8'hC3; RF_RD_VLD = 1'b1;
        tick();
        RF_RD_DATA = 8'h00; RF_RD_VLD = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (TX_D_VLD !== 1'b0 || TX_P_DATA !== 8'hC3 || CTRL_BUSY !== 1'b1) bad = 1'b1;
            tick();
        end
        check("bp_stall", bad, 0);
        TX_BUSY = 1'b0;
        tick();
        check("bp_tx_vld", TX_D_VLD, 1);
        check("bp_tx_data", TX_P_DATA, 8'hC3);
        TX_BUSY = 1'b1;
        tick();
        TX_BUSY = 1'b0;
        check("bp_tx_drop", TX_D_VLD, 0);

        // Read to out-of-range address 0x1F
        rd0 = rd_cnt; err0 = err_cnt;
        send_byte(8'hBB);
        send_byte(8'h1F);
        check("badaddr_err", CMD_ERR, 1);
        check("badaddr_rd_en", RF_RD_EN, 0);
        tick();
        check("badaddr_err_pulse", CMD_ERR, 0);
        check("badaddr_idle", CTRL_BUSY, 0);
        check("badaddr_no_rd", rd_cnt - rd0, 0);
        check("badaddr_err_cnt", err_cnt - err0, 1);

        // Unknown command byte
        send_byte(8'h11);
        check("unk_err", CMD_ERR, 0);
        check("unk_idle", CTRL_BUSY, 0);

        // Extra byte during RD_WAIT
        send_byte(8'hBB);
        send_byte(8'h04);
        tick();
        send_byte(8'h99);
        check("extra_err", CMD_ERR, 1);
        check("extra_busy", CTRL_BUSY, 1);
        RF_RD_DATA = 8'h77; RF_RD_VLD = 1'b1;
        tick();
        RF_RD_VLD = 1'b0;
        check("extra_tx_vld", TX_D_VLD, 1);
        check("extra_tx_data", TX_P_DATA, 8'h77);
        TX_BUSY = 1'b1;
        tick();
        TX_BUSY = 1'b0;
        check("extra_idle", CTRL_BUSY, 0);

        // Reset mid-frame
        wr0 = wr_cnt;
        send_byte(8'hAA);
        send_byte(8'h05);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mrst_idle", CTRL_BUSY, 0);
        check("mrst_addr", RF_ADDR, 0);
        send_byte(8'hAA);
        send_byte(8'h02);
        send_byte(8'hFF);
        check("mrst_wr_addr", RF_ADDR, 2);
        check("mrst_wr_data", RF_WR_DATA, 8'hFF);
        tick();
        check("mrst_wr_count", wr_cnt - wr0, 1);
        check("mrst_last_addr", last_wr_addr, 2);

        // Partial frame followed by a long idle gap
        wr0 = wr_cnt; err0 = err_cnt;
        send_byte(8'hAA);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (CMD_ERR) seen = 1'b1;
            tick();
        end
`ifdef FRAME_TIMEOUT_EN
        check("to_err_seen", seen, 1);
        check("to_idle", CTRL_BUSY, 0);
        send_byte(8'h05);
        tick(); tick();
        check("to_no_frame", CTRL_BUSY, 0);
        check("to_no_write", wr_cnt - wr0, 0);
        check("to_err_cnt", err_cnt - err0, 1);
`else
        check("nto_no_err", seen, 0);
        check("nto_busy", CTRL_BUSY, 1);
        send_byte(8'h05);
        send_byte(8'h66);
        check("nto_wr_addr", RF_ADDR, 5);
        check("nto_wr_data", RF_WR_DATA, 8'h66);
        tick();
        check("nto_wr_count", wr_cnt - wr0, 1);
`endif

        check("never_both_strobes", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
